// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches 32-bit MIPS instruction words from instruction memory and hands
//   them to the main decoder over a valid/ready handshake. When the decoder
//   accepts an instruction, the next PC is computed from that instruction and
//   the decoder's branch/jump outputs plus the ALU zero flag.
//
//   Optional feature macro: IFU_TIMEOUT_EN
//     When defined, a wait counter runs while a fetch is outstanding. After
//     TIMEOUT cycles without imem_ack the unit raises a sticky o_fetch_err
//     and parks in HALT until reset. When undefined, a fetch waits forever
//     and o_fetch_err is constant 0.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous, active-high reset
//   o_imem_req     fetch request, held with o_imem_addr stable until ack
//   o_imem_addr    byte address of the word being fetched (equals o_pc)
//   i_imem_ack     read data valid this cycle
//   i_imem_rdata   instruction word, captured on o_imem_req & i_imem_ack
//   o_instr        registered instruction presented to the decoder
//   o_opcode       o_instr[31:26]
//   o_pc           address of the presented instruction
//   o_pc_plus4     o_pc + 4 (mod 2^32)
//   o_instr_valid  o_instr/o_opcode/o_pc are valid
//   i_instr_ready  decoder accepts (handshake on valid & ready)
//   i_branch       decoder branch for the presented instruction
//   i_zero         ALU zero flag for the presented instruction
//   i_jump         decoder jump for the presented instruction
//   o_fetch_err    sticky fetch timeout error
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic        i_jump,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_req;
    logic        r_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_next_pc;
    logic        w_fetch_done;
    logic        w_hs;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jmp_tgt  = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // r_req is only ever high in FETCH, so an ack seen while it is low
    // (outside FETCH, or in the first cycle after reset) is ignored.
    assign w_fetch_done = r_req & i_imem_ack;
    assign w_hs         = r_valid & i_instr_ready;

    // Jump wins over a taken branch.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jump)
            w_next_pc = w_jmp_tgt;
        else if (i_branch && i_zero)
            w_next_pc = w_pc_plus4 + w_br_off;
    end

`ifdef IFU_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CW-1:0] r_cnt;
    logic          w_cnt_last;
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_instr <= i_imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_VALID;
                    end else begin
                        // First FETCH cycle after reset raises the request;
                        // afterwards it simply stays high until ack.
                        r_req <= 1'b1;
`ifdef IFU_TIMEOUT_EN
                        if (r_req) begin
                            if (w_cnt_last) begin
                                r_err   <= 1'b1;
                                r_req   <= 1'b0;
                                r_state <= S_HALT;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                S_VALID: begin
                    if (w_hs) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
`ifdef IFU_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_HALT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_opcode      = r_instr[31:26];
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_instr_valid = r_valid;
    assign o_fetch_err   = r_err;

endmodule
